key_expansion_iter: RTL and testbench

Iterative AES-128 key expansion engine. It takes a 128-bit cipher key and produces the full 1408-bit expanded key, that is round keys 0 through 10. It sits directly upstream of the round-key register stage and drives that stage's `expanded_key` bus. It computes one round key per clock, so it needs only one SubWord datapath and one Rcon generator, under a start/busy/done handshake.

---
 rtl/key_expansion_iter.sv | 121 ++++++++++++
 tb/tb_key_expansion_iter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_iter.sv
// Iterative AES-128 key expansion: one round key per clock from a single SubWord path.
// Drives the full 1408-bit expanded key bus for the downstream round-key register stage.

module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);
  // Row 0 of the FIPS-197 table sits in the top bits, so entry x lives at index ~x.
  localparam logic [255:0][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = SBOX_TABLE[~x];
endmodule

module key_expansion_iter (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [127:0]   key,
  output logic [1407:0]  expanded_key,
  output logic           busy,
  output logic           done,
  output logic           valid
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  logic [0:0]         state;
  logic [3:0]         rnd;
  logic [7:0]         rcon;
  logic [10:0][127:0] slices;

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_next;

  assign expanded_key = slices;

  // Previous round key feeds the next; out-of-range indices only occur outside EXPAND.
  always_comb begin
    prev_idx = rnd - 4'd1;
    prev     = '0;
    if (prev_idx <= 4'd10) begin
      prev = slices[prev_idx];
    end
  end

  assign {p0, p1, p2, p3} = prev;
  assign rot = {p3[23:0], p3[31:24]};

  aes_sbox u_sbox0 (.x(rot[31:24]), .s(sub[31:24]));
  aes_sbox u_sbox1 (.x(rot[23:16]), .s(sub[23:16]));
  aes_sbox u_sbox2 (.x(rot[15:8]),  .s(sub[15:8]));
  aes_sbox u_sbox3 (.x(rot[7:0]),   .s(sub[7:0]));

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = p0 ^ t;
  assign n1 = p1 ^ n0;
  assign n2 = p2 ^ n1;
  assign n3 = p3 ^ n2;

  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      slices <= '0;
      rnd    <= 4'd0;
      rcon   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            slices[0] <= key;
            rnd       <= 4'd1;
            rcon      <= 8'h01;
            busy      <= 1'b1;
            valid     <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          slices[rnd] <= {n0, n1, n2, n3};
          rcon        <= rcon_next;
          rnd         <= rnd + 4'd1;
          // Round 10 is the last slice; the result becomes usable the next cycle.
          if (rnd == 4'd10) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_expansion_iter.sv
// Scoreboard bench for key_expansion_iter: drivers push expected round keys,
// a negedge monitor pops and compares whenever done pulses.

module tb_key_expansion_iter;
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key;
  logic [1407:0] expanded_key;
  logic          busy;
  logic          done;
  logic          valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic prev_done = 1'b0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_S1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_S2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_S10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ZERO_S1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_S2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_S10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] k;
    logic [127:0] s1;
    logic [127:0] s2;
    logic [127:0] s10;
    int           acc;
  } exp_t;

  exp_t sb[$];

  key_expansion_iter dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .key(key),
    .expanded_key(expanded_key),
    .busy(busy),
    .done(done),
    .valid(valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [127:0] slice(input int r);
    return expanded_key[128*r +: 128];
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expansion.
  always @(negedge clk) begin
    if (prev_done) check_output("done_width", {127'b0, done}, 128'd0);
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending expansion", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("slice0", slice(0), e.k);
        check_output("slice1", slice(1), e.s1);
        check_output("slice2", slice(2), e.s2);
        check_output("slice10", slice(10), e.s10);
        check_output("valid_at_done", {127'b0, valid}, 128'd1);
        check_output("busy_at_done", {127'b0, busy}, 128'd0);
        check_output("latency", 128'(cyc - e.acc), 128'd10);
      end
    end
    prev_done = done;
  end

  task automatic apply_stimulus(input logic [127:0] k, input logic [127:0] s1,
                                input logic [127:0] s2, input logic [127:0] s10,
                                input bit expect_done);
    exp_t e;
    start = 1'b1;
    key   = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_done) begin
      e.k = k; e.s1 = s1; e.s2 = s2; e.s10 = s10; e.acc = cyc;
      sb.push_back(e);
    end
    check_output("busy_after_accept", {127'b0, busy}, 128'd1);
    check_output("valid_after_accept", {127'b0, valid}, 128'd0);
    check_output("slice0_after_accept", slice(0), k);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    @(negedge clk);
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected a done pulse", bound);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, {127'b0, busy}, 128'd0);
    check_output({tag, "_done"}, {127'b0, done}, 128'd0);
    check_output({tag, "_valid"}, {127'b0, valid}, 128'd0);
    check_output({tag, "_bus_nonzero"}, {127'b0, (expanded_key != '0)}, 128'd0);
  endtask

  initial begin
    logic [1407:0] snap;
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    $display("[TB] FIPS-197 key");
    @(posedge clk); #1;
    apply_stimulus(FIPS_KEY, FIPS_S1, FIPS_S2, FIPS_S10, 1'b1);
    wait_done(20);

    $display("[TB] all-zero key");
    @(posedge clk); #1;
    apply_stimulus(ZERO_KEY, ZERO_S1, ZERO_S2, ZERO_S10, 1'b1);
    wait_done(20);

    $display("[TB] start while busy with key churn");
    @(posedge clk); #1;
    apply_stimulus(FIPS_KEY, FIPS_S1, FIPS_S2, FIPS_S10, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      start = (i == 3 || i == 7);
      key   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(20);
    repeat (5) @(negedge clk);

    $display("[TB] reset mid-expansion");
    @(posedge clk); #1;
    apply_stimulus(FIPS_KEY, FIPS_S1, FIPS_S2, FIPS_S10, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("midrst");
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    apply_stimulus(ZERO_KEY, ZERO_S1, ZERO_S2, ZERO_S10, 1'b1);
    wait_done(20);

    $display("[TB] back-to-back starts");
    @(posedge clk); #1;
    apply_stimulus(FIPS_KEY, FIPS_S1, FIPS_S2, FIPS_S10, 1'b1);
    wait_done(20);
    apply_stimulus(ZERO_KEY, ZERO_S1, ZERO_S2, ZERO_S10, 1'b1);
    wait_done(20);

    $display("[TB] hold after done");
    snap = expanded_key;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("hold_valid", {127'b0, valid}, 128'd1);
      check_output("hold_bus_changed", {127'b0, (expanded_key !== snap)}, 128'd0);
      check_output("hold_slice10", slice(10), ZERO_S10);
    end

    check_output("pending_runs", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
